// File: rtl/home_auto_pkg.sv
// Shared home-automation definitions: time field widths, legal ranges and the
// hour/minute struct passed between the RTC consumers.
package home_auto_pkg;

    localparam int unsigned HOUR_W   = 5;
    localparam int unsigned MIN_W    = 6;
    localparam int unsigned MAX_HOUR = 23;
    localparam int unsigned MAX_MIN  = 59;

    typedef struct packed {
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  minute;
    } time_hm_t;

    // Out-of-range times are treated as "no information": they neither match
    // a slot nor release a lockout.
    function automatic logic time_valid(input time_hm_t t);
        return (t.hour <= HOUR_W'(MAX_HOUR)) && (t.minute <= MIN_W'(MAX_MIN));
    endfunction

endpackage

// File: rtl/feed_slot_match.sv
// One feeding slot: compares the current time against a fixed hour/minute and
// holds the per-slot lockout flag so a slot fires once per occurrence of its
// minute.
//
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   now       - current time (hour/minute)
//   valid     - current time is in range
//   enable    - global scheduler enable
//   match     - slot time equals current valid time and slot is enabled
//   trigger   - slot fires this cycle (enabled, matching, not locked out)
module feed_slot_match
    import home_auto_pkg::*;
#(
    parameter logic [HOUR_W-1:0] SlotHour = '0,
    parameter logic [MIN_W-1:0]  SlotMin  = '0,
    parameter bit                SlotEn   = 1'b0
) (
    input  logic     clk,
    input  logic     rst,
    input  time_hm_t now,
    input  logic     valid,
    input  logic     enable,
    output logic     match,
    output logic     trigger
);

    logic fired_q, fired_d;

    always_comb begin
        match   = valid && SlotEn && (now.hour == SlotHour) && (now.minute == SlotMin);
        trigger = enable && match && !fired_q;
    end

    // Lockout only releases on a valid, non-matching time; an invalid time
    // leaves it untouched. Disabled cycles don't set it, so a late enable
    // within the minute still fires.
    always_comb begin
        fired_d = fired_q;
        if (trigger) begin
            fired_d = 1'b1;
        end else if (valid && !match) begin
            fired_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fired_q <= 1'b0;
        end else begin
            fired_q <= fired_d;
        end
    end

endmodule

// File: rtl/pet_feeder_scheduler.sv
// Time-of-day feed scheduler. Up to four fixed slots are compared against the
// RTC time; an enabled slot entering its minute produces a fixed-length
// registered dispense pulse.
//
// Ports:
//   clk           - system clock, rising edge
//   rst           - synchronous active-high reset
//   hour, minute  - current time from the RTC (0..23 / 0..59)
//   enable        - global enable; low aborts any pulse on the next edge
//   dispense_food - dispense pulse, decoded from the pulse counter register
module pet_feeder_scheduler
    import home_auto_pkg::*;
#(
    parameter int unsigned NUM_SLOTS       = 4,
    parameter int unsigned SLOT0_HOUR      = 7,
    parameter int unsigned SLOT0_MIN       = 30,
    parameter int unsigned SLOT1_HOUR      = 18,
    parameter int unsigned SLOT1_MIN       = 0,
    parameter int unsigned SLOT2_HOUR      = 12,
    parameter int unsigned SLOT2_MIN       = 0,
    parameter int unsigned SLOT3_HOUR      = 22,
    parameter int unsigned SLOT3_MIN       = 0,
    parameter logic [3:0]  SLOT_MASK       = 4'b0011,
    parameter int unsigned DISPENSE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [HOUR_W-1:0] hour,
    input  logic [MIN_W-1:0]  minute,
    input  logic              enable,
    output logic              dispense_food
);

    localparam int unsigned SlotHours [4] = '{SLOT0_HOUR, SLOT1_HOUR, SLOT2_HOUR, SLOT3_HOUR};
    localparam int unsigned SlotMins  [4] = '{SLOT0_MIN, SLOT1_MIN, SLOT2_MIN, SLOT3_MIN};

    time_hm_t   now;
    logic       valid;
    logic [3:0] slot_match;
    logic [3:0] slot_trig;
    logic       fire;
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        now.hour   = hour;
        now.minute = minute;
        valid      = time_valid(now);
    end

    for (genvar i = 0; i < 4; i++) begin : g_slot
        if (i < NUM_SLOTS) begin : g_used
            feed_slot_match #(
                .SlotHour (HOUR_W'(SlotHours[i])),
                .SlotMin  (MIN_W'(SlotMins[i])),
                .SlotEn   (SLOT_MASK[i])
            ) u_slot (
                .clk     (clk),
                .rst     (rst),
                .now     (now),
                .valid   (valid),
                .enable  (enable),
                .match   (slot_match[i]),
                .trigger (slot_trig[i])
            );
        end else begin : g_unused
            assign slot_match[i] = 1'b0;
            assign slot_trig[i]  = 1'b0;
        end
    end

    // Slots sharing a time collapse into a single trigger.
    assign fire = |(slot_trig & slot_match);

    // Retrigger reloads rather than accumulates, so overlapping slots extend
    // the pulse instead of lengthening it by a multiple.
    always_comb begin
        cnt_d = cnt_q;
        if (!enable) begin
            cnt_d = 8'd0;
        end else if (fire) begin
            cnt_d = 8'(DISPENSE_CYCLES);
        end else if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign dispense_food = (cnt_q != 8'd0);

endmodule

// File: tb/tb_pet_feeder_scheduler.sv
// Directed bench for pet_feeder_scheduler. Two instances share stimulus:
//   dut_a - default parameters (2-cycle pulse, slots 07:30 and 18:00 enabled)
//   dut_b - 5-cycle pulse, slots 0 and 1 both at 07:30
// The driver applies one vector per cycle and queues the hand-computed output
// expected after the following rising edge; the monitor pops and compares.
module tb_pet_feeder_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] hour;
    logic [5:0] minute;
    logic       enable;
    logic       dispense_a;
    logic       dispense_b;

    always #5 clk = ~clk;

    pet_feeder_scheduler dut_a (
        .clk           (clk),
        .rst           (rst),
        .hour          (hour),
        .minute        (minute),
        .enable        (enable),
        .dispense_food (dispense_a)
    );

    pet_feeder_scheduler #(
        .DISPENSE_CYCLES (5),
        .SLOT1_HOUR      (7),
        .SLOT1_MIN       (30)
    ) dut_b (
        .clk           (clk),
        .rst           (rst),
        .hour          (hour),
        .minute        (minute),
        .enable        (enable),
        .dispense_food (dispense_b)
    );

    typedef struct {
        logic       rst;
        logic [4:0] h;
        logic [5:0] m;
        logic       en;
        logic       exp_a;
        logic       exp_b;
    } vec_t;

    typedef struct {
        int   idx;
        logic exp_a;
        logic exp_b;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    bit   drv_done = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic add(input logic r, input int h, input int m, input logic en,
                       input logic ea, input logic eb);
        vec_t v;
        v.rst   = r;
        v.h     = 5'(h);
        v.m     = 6'(m);
        v.en    = en;
        v.exp_a = ea;
        v.exp_b = eb;
        vecs.push_back(v);
    endtask

    // Driver
    initial begin
        rst    = 1'b1;
        hour   = '0;
        minute = '0;
        enable = 1'b0;

        // reset and idle
        add(1, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0);
        // 07:30 held: single pulse, then lockout (b: both flags set, no refire)
        add(0, 7, 30, 1, 1, 1);
        add(0, 7, 30, 1, 1, 1);
        add(0, 7, 30, 1, 0, 1);
        add(0, 7, 30, 1, 0, 1);
        add(0, 7, 30, 1, 0, 1);
        add(0, 7, 30, 1, 0, 0);
        add(0, 7, 30, 1, 0, 0);
        add(0, 7, 30, 1, 0, 0);
        // abort by enable low, then 08:00 stays quiet
        add(0, 8, 0, 1, 0, 0);
        add(0, 7, 30, 1, 1, 1);
        add(0, 7, 30, 0, 0, 0);
        add(0, 8, 0, 0, 0, 0);
        add(0, 8, 0, 1, 0, 0);
        // 07:30 with enable low, then late enable fires
        add(0, 7, 30, 0, 0, 0);
        add(0, 7, 30, 0, 0, 0);
        add(0, 7, 30, 0, 0, 0);
        add(0, 7, 30, 1, 1, 1);
        add(0, 7, 30, 1, 1, 1);
        // 07:31 releases lockout, 07:30 refires (b reloads mid-pulse)
        add(0, 7, 31, 1, 0, 1);
        add(0, 7, 30, 1, 1, 1);
        add(0, 7, 30, 1, 1, 1);
        add(0, 7, 30, 1, 0, 1);
        // 12:00 is masked off
        add(0, 12, 0, 1, 0, 1);
        add(0, 12, 0, 1, 0, 1);
        add(0, 12, 0, 1, 0, 0);
        // 18:00 fires on a only
        add(0, 18, 0, 1, 1, 0);
        add(0, 18, 0, 1, 1, 0);
        add(0, 18, 0, 1, 0, 0);
        // invalid times neither fire nor release the lockout
        add(0, 7, 30, 1, 1, 1);
        add(0, 7, 30, 1, 1, 1);
        add(0, 24, 0, 1, 0, 1);
        add(0, 7, 60, 1, 0, 1);
        add(0, 7, 30, 1, 0, 1);
        add(0, 7, 30, 1, 0, 0);
        // reset mid-pulse kills it and clears the lockout
        add(0, 8, 0, 1, 0, 0);
        add(0, 7, 30, 1, 1, 1);
        add(1, 7, 30, 1, 0, 0);
        add(0, 7, 30, 1, 1, 1);
        add(0, 7, 30, 1, 1, 1);
        add(0, 7, 30, 1, 0, 1);
        add(1, 7, 30, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            exp_t e;
            @(negedge clk);
            rst    = vecs[i].rst;
            hour   = vecs[i].h;
            minute = vecs[i].m;
            enable = vecs[i].en;
            e.idx   = i;
            e.exp_a = vecs[i].exp_a;
            e.exp_b = vecs[i].exp_b;
            exp_q.push_back(e);
        end
        drv_done = 1'b1;
    end

    // Monitor / scoreboard
    initial begin
        int cycles = 0;
        forever begin
            @(posedge clk);
            #1;
            cycles++;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                n_cmp++;
                if (dispense_a !== e.exp_a) begin
                    n_bad++;
                    $display("FAIL vec%0d dispense_food(dut_a): got %b want %b",
                             e.idx, dispense_a, e.exp_a);
                end
                n_cmp++;
                if (dispense_b !== e.exp_b) begin
                    n_bad++;
                    $display("FAIL vec%0d dispense_food(dut_b): got %b want %b",
                             e.idx, dispense_b, e.exp_b);
                end
            end else if (drv_done) begin
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
                $finish;
            end
            if (cycles > 2000) begin
                n_cmp++;
                n_bad++;
                $display("FAIL watchdog: got %0d cycles want <= 2000", cycles);
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
                $finish;
            end
        end
    end

endmodule
